// File: rtl/sm_hex_scan_display.sv
// Time-multiplexed hex driver for an N-digit 7-segment bank with hold shadow, LZ blanking and dp.
// Latency: data->shadow 1 cycle, shadow/scan state->pins 1 cycle (all outputs registered).
// Backpressure: none; free-running scan, inputs sampled every cycle.
module sm_hex_scan_display #(
    parameter int DIGITS      = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int SCAN_DIV    = 50000,
    parameter int BLANK_CYC   = 1,
    parameter int SEG_ACT_LOW = 1,
    parameter int DIG_ACT_LOW = 0
) (
    input  logic                  clkIn,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  hold,
    input  logic                  load,
    input  logic                  blankLz,
    input  logic [DIGITS-1:0]     dpMask,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     digSel
);

    localparam int NW = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CW = $clog2(SCAN_DIV);

    localparam logic SEG_INV = (SEG_ACT_LOW != 0);
    localparam logic DIG_INV = (DIG_ACT_LOW != 0);

    localparam logic [6:0]        SEG_OFF = {7{SEG_INV}};
    localparam logic              DP_OFF  = SEG_INV;
    localparam logic [DIGITS-1:0] DIG_OFF = {DIGITS{DIG_INV}};

    logic [NW-1:0] data_ext;
    logic [NW-1:0] shadow;
    logic [CW-1:0] cnt;
    logic [IW-1:0] idx;

    // Fit data to exactly one nibble per digit: truncate or zero-extend.
    generate
        if (DATA_WIDTH > NW) begin : g_trunc
            logic unused_hi;
            assign unused_hi = ^data[DATA_WIDTH-1:NW];
            assign data_ext  = data[NW-1:0];
        end else if (DATA_WIDTH == NW) begin : g_exact
            assign data_ext = data;
        end else begin : g_zext
            assign data_ext = {{(NW - DATA_WIDTH){1'b0}}, data};
        end
    endgenerate

    function automatic logic [6:0] hexfont(input logic [3:0] n);
        logic [6:0] f;
        case (n)
            4'h0:    f = 7'b1111110;
            4'h1:    f = 7'b0110000;
            4'h2:    f = 7'b1101101;
            4'h3:    f = 7'b1111001;
            4'h4:    f = 7'b0110011;
            4'h5:    f = 7'b1011011;
            4'h6:    f = 7'b1011111;
            4'h7:    f = 7'b1110000;
            4'h8:    f = 7'b1111111;
            4'h9:    f = 7'b1111011;
            4'hA:    f = 7'b1110111;
            4'hB:    f = 7'b0011111;
            4'hC:    f = 7'b1001110;
            4'hD:    f = 7'b0111101;
            4'hE:    f = 7'b1001111;
            default: f = 7'b1000111;
        endcase
        return f;
    endfunction

    always_ff @(posedge clkIn or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '0;
        end else if (!hold || load) begin
            shadow <= data_ext;
        end
    end

    always_ff @(posedge clkIn or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (cnt == CW'(SCAN_DIV - 1)) begin
            cnt <= '0;
            idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // zero_from[i]: nibbles i..DIGITS-1 of the shadow are all zero.
    logic [DIGITS:0]     zero_from;
    logic [3:0]          nib;
    logic                lz_blank;
    logic                dp_bit;
    logic [DIGITS-1:0]   sel_oh;
    logic                slot_blank;

    always_comb begin
        zero_from         = '0;
        zero_from[DIGITS] = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_from[i] = zero_from[i+1] && (shadow[4*i +: 4] == 4'h0);
        end
    end

    always_comb begin
        nib      = 4'h0;
        lz_blank = 1'b0;
        dp_bit   = 1'b0;
        sel_oh   = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i)) begin
                nib       = shadow[4*i +: 4];
                lz_blank  = blankLz && (i != 0) && zero_from[i];
                dp_bit    = dpMask[i];
                sel_oh[i] = 1'b1;
            end
        end
        slot_blank = (cnt < CW'(BLANK_CYC));
    end

    always_ff @(posedge clkIn or negedge rst_n) begin
        if (!rst_n) begin
            seg    <= SEG_OFF;
            dp     <= DP_OFF;
            digSel <= DIG_OFF;
        end else if (slot_blank) begin
            seg    <= SEG_OFF;
            dp     <= DP_OFF;
            digSel <= DIG_OFF;
        end else begin
            seg    <= (lz_blank ? 7'b0000000 : hexfont(nib)) ^ {7{SEG_INV}};
            dp     <= dp_bit ^ SEG_INV;
            digSel <= sel_oh ^ {DIGITS{DIG_INV}};
        end
    end

endmodule
